// File: rtl/idex_operand_stage.sv
// ID->EX operand stage: registers one decoded instruction per handshake, forwards MEM/WB
// results onto the Alu operands, inserts a single bubble on load-use, holds on backpressure.
module idex_operand_stage #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           id_valid,
  output logic           id_ready,
  input  logic [RAW-1:0] id_rs_addr,
  input  logic [RAW-1:0] id_rt_addr,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic           id_use_imm,
  input  logic [2:0]     id_op,
  input  logic           id_unsig,
  input  logic [RAW-1:0] id_rd_addr,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           ex_ready,
  input  logic           mem_reg_write,
  input  logic [RAW-1:0] mem_rd_addr,
  input  logic [DW-1:0]  mem_result,
  input  logic           wb_reg_write,
  input  logic [RAW-1:0] wb_rd_addr,
  input  logic [DW-1:0]  wb_result,
  output logic           ex_valid,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [2:0]     alu_op,
  output logic           alu_unsig,
  output logic [RAW-1:0] ex_rd_addr,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic [DW-1:0]  ex_rt_fwd
);

  logic [RAW-1:0] rs_addr_q, rt_addr_q;
  logic [DW-1:0]  rs_val_q, rt_val_q, imm_q;
  logic           use_imm_q;
  logic           hazard, transfer;
  logic [DW-1:0]  rs_fwd, rt_fwd;

  // MEM beats WB; register 0 always keeps its stored value.
  function automatic logic [DW-1:0] fwd(
    input logic [RAW-1:0] addr,
    input logic [DW-1:0]  stored,
    input logic           m_we,
    input logic [RAW-1:0] m_rd,
    input logic [DW-1:0]  m_res,
    input logic           w_we,
    input logic [RAW-1:0] w_rd,
    input logic [DW-1:0]  w_res
  );
    logic [DW-1:0] r;
    r = stored;
    if (addr != '0) begin
      if (m_we && (m_rd == addr))      r = m_res;
      else if (w_we && (w_rd == addr)) r = w_res;
    end
    return r;
  endfunction

  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rd_addr != '0) & id_valid &
             ((ex_rd_addr == id_rs_addr) | ((ex_rd_addr == id_rt_addr) & ~id_use_imm));
    id_ready = (~ex_valid | ex_ready) & ~hazard & ~flush;
    transfer = id_valid & id_ready;
  end

  always_comb begin
    rs_fwd = fwd(rs_addr_q, rs_val_q, mem_reg_write, mem_rd_addr, mem_result,
                 wb_reg_write, wb_rd_addr, wb_result);
    rt_fwd = fwd(rt_addr_q, rt_val_q, mem_reg_write, mem_rd_addr, mem_result,
                 wb_reg_write, wb_rd_addr, wb_result);
    alu_a     = rs_fwd;
    alu_b     = use_imm_q ? imm_q : rt_fwd;
    ex_rt_fwd = rt_fwd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rs_val_q     <= '0;
      rt_val_q     <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      alu_op       <= '0;
      alu_unsig    <= 1'b0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
      ex_valid     <= 1'b1;
      rs_addr_q    <= id_rs_addr;
      rt_addr_q    <= id_rt_addr;
      rs_val_q     <= id_rs_data;
      rt_val_q     <= id_rt_data;
      imm_q        <= id_imm;
      use_imm_q    <= id_use_imm;
      alu_op       <= id_op;
      alu_unsig    <= id_unsig;
      ex_rd_addr   <= id_rd_addr;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end else if (ex_valid) begin
      // Stalled: capture a WB retirement so the value survives after WB moves on.
      if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr_q)) rs_val_q <= wb_result;
      if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rt_addr_q)) rt_val_q <= wb_result;
    end
  end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: directed literal checks plus randomized traffic against an
// instruction-record reference model compared every cycle.
module tb_idex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_unsig, id_reg_write, id_mem_read, ex_ready;
  logic [2:0]  id_op;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, alu_unsig, ex_reg_write, ex_mem_read;
  logic [31:0] alu_a, alu_b, ex_rt_fwd;
  logic [2:0]  alu_op;
  logic [4:0]  ex_rd_addr;

  idex_operand_stage #(.DW(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_use_imm(id_use_imm), .id_op(id_op),
    .id_unsig(id_unsig), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_ready(ex_ready), .mem_reg_write(mem_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_result(wb_result), .ex_valid(ex_valid), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rt_fwd(ex_rt_fwd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  int model_acc = 0;
  int dut_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction currently occupying EX, as a plain record.
  typedef struct {
    bit          v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv, imm;
    bit          ui, un, rw, mr;
    logic [2:0]  op;
  } ex_t;
  ex_t m;

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] s);
    if (a == 0) return s;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return s;
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = m.v && m.mr && m.rd != 0 && id_valid &&
         (m.rd == id_rs_addr || (m.rd == id_rt_addr && !id_use_imm));
    return (!m.v || ex_ready) && !hz && !flush;
  endfunction

  always @(posedge clk) begin
    if (!rst && id_valid && id_ready) dut_acc++;
    if (rst) begin
      m = '{v:0, rs:0, rt:0, rd:0, rsv:0, rtv:0, imm:0, ui:0, un:0, rw:0, mr:0, op:0};
    end else if (flush) begin
      m.v = 0;
    end else if (id_valid && m_ready()) begin
      m = '{v:1, rs:id_rs_addr, rt:id_rt_addr, rd:id_rd_addr, rsv:id_rs_data,
            rtv:id_rt_data, imm:id_imm, ui:id_use_imm, un:id_unsig, rw:id_reg_write,
            mr:id_mem_read, op:id_op};
      model_acc++;
    end else if (ex_ready) begin
      m.v = 0;
    end else if (m.v && wb_reg_write && wb_rd_addr != 0) begin
      if (wb_rd_addr == m.rs) m.rsv = wb_result;
      if (wb_rd_addr == m.rt) m.rtv = wb_result;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_ex_valid", {31'b0, ex_valid}, {31'b0, m.v});
      chk("m_id_ready", {31'b0, id_ready}, {31'b0, m_ready()});
      if (m.v) begin
        chk("m_alu_a", alu_a, m_fwd(m.rs, m.rsv));
        chk("m_alu_b", alu_b, m.ui ? m.imm : m_fwd(m.rt, m.rtv));
        chk("m_rt_fwd", ex_rt_fwd, m_fwd(m.rt, m.rtv));
        chk("m_ctrl", {20'b0, alu_op, alu_unsig, ex_rd_addr, ex_reg_write, ex_mem_read},
            {20'b0, m.op, m.un, m.rd, m.rw, m.mr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; ex_ready = 1;
    mem_reg_write = 0; wb_reg_write = 0;
    mem_rd_addr = 0; wb_rd_addr = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [31:0] imm, input bit ui,
                           input logic [4:0] rd, input bit rw, input bit mr);
    id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = ui; id_op = 3'b010; id_unsig = 0; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  initial begin
    rst = 1;
    idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cmp_en = 1;
    tick();
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'b0, alu_op}, 32'd0);
    rst = 0;
    #1 chk("rst_id_ready", {31'b0, id_ready}, 32'd1);

    // MEM over WB forwarding, then WB alone
    set_instr(3, 0, 5, 0, 32'h77, 1, 9, 1, 0);
    id_valid = 1;
    tick();
    id_valid = 0; ex_ready = 0;
    mem_reg_write = 1; mem_rd_addr = 3; mem_result = 32'hA;
    wb_reg_write = 1; wb_rd_addr = 3; wb_result = 32'hB;
    #1 chk("fwd_mem", alu_a, 32'hA);
    chk("imm_not_fwd", alu_b, 32'h77);
    mem_reg_write = 0;
    #1 chk("fwd_wb", alu_a, 32'hB);

    // x0 never forwarded
    wb_reg_write = 0; ex_ready = 1;
    set_instr(0, 0, 0, 0, 0, 1, 1, 1, 0);
    id_valid = 1;
    tick();
    id_valid = 0; ex_ready = 0;
    mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'hFFFF;
    wb_reg_write = 1; wb_rd_addr = 0; wb_result = 32'hEEEE;
    #1 chk("x0_no_fwd", alu_a, 32'd0);

    // load-use: one bubble, then WB value
    idle();
    set_instr(2, 0, 32'h100, 0, 32'h8, 1, 4, 1, 1);
    id_valid = 1;
    tick();
    set_instr(4, 1, 32'hDEAD, 32'h1, 0, 0, 5, 1, 0);
    #1 chk("lu_stall_ready", {31'b0, id_ready}, 32'd0);
    tick();
    #1 chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu_ready_again", {31'b0, id_ready}, 32'd1);
    tick();
    id_valid = 0;
    wb_reg_write = 1; wb_rd_addr = 4; wb_result = 32'h1234;
    #1 chk("lu_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_alu_a", alu_a, 32'h1234);

    // stall with WB retiring into rt
    idle();
    set_instr(1, 7, 32'h3, 32'h11, 0, 0, 8, 1, 0);
    id_valid = 1;
    tick();
    id_valid = 0; ex_ready = 0;
    #1 chk("stall_b0", alu_b, 32'h11);
    tick();
    wb_reg_write = 1; wb_rd_addr = 7; wb_result = 32'h55;
    #1 chk("stall_held", {31'b0, ex_valid}, 32'd1);
    tick();
    wb_reg_write = 0;
    #1 chk("stall_snoop", alu_b, 32'h55);
    tick();
    ex_ready = 1;
    #1 chk("stall_release_b", alu_b, 32'h55);
    chk("stall_release_v", {31'b0, ex_valid}, 32'd1);
    tick();

    // flush concurrent with an offered instruction
    set_instr(6, 6, 32'h9, 32'h9, 0, 0, 10, 1, 0);
    id_valid = 1;
    tick();
    flush = 1;
    #1 chk("flush_ready", {31'b0, id_ready}, 32'd0);
    tick();
    flush = 0; id_valid = 0;
    #1 chk("flush_empty", {31'b0, ex_valid}, 32'd0);

    // randomized traffic, including reset and flush mid-flight
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 5);
      id_valid = ($urandom_range(0, 99) < 70);
      ex_ready = ($urandom_range(0, 99) < 70);
      set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 35));
      id_op = 3'($urandom_range(0, 7));
      id_unsig = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_rd_addr = 5'($urandom_range(0, 7));
      mem_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_rd_addr = 5'($urandom_range(0, 7));
      wb_result = $urandom;
      tick();
    end
    rst = 0;
    idle();
    tick();
    chk("handshakes", 32'(dut_acc), 32'(model_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
